// File: rtl/digit_sequencer_if.sv
// Load handshake between a value producer and digit_sequencer.
// A transfer happens on any clock edge where i_load_valid and o_load_ready are both 1.
interface digit_sequencer_if;
  logic        i_load_valid;
  logic [15:0] i_load_value;
  logic        o_load_ready;

  modport master (
    output i_load_valid,
    output i_load_value,
    input  o_load_ready
  );

  modport slave (
    input  i_load_valid,
    input  i_load_value,
    output o_load_ready
  );
endinterface

// File: rtl/digit_sequencer.sv
// Four-digit BCD frame-tick counter with a frame-synchronised load and a registered glyph-digit mux.
// Optional feature: define DIGIT_SEQ_LEADING_BLANK_EN to blank leading zeros on slots 0..2.
module digit_sequencer #(
  parameter int unsigned FRAMES_PER_TICK = 60,
  parameter int unsigned FRAME_LINE      = 480
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [9:0]               i_hpos,
  input  logic [9:0]               i_vpos,
  input  logic                     i_run,
  input  logic                     i_clear,
  digit_sequencer_if.slave         load,
  output logic [3:0]               o_digit,
  output logic [15:0]              o_value,
  output logic                     o_wrap
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LOAD_WAIT
  } state_t;

  localparam logic [7:0] TICK_LAST   = 8'(FRAMES_PER_TICK - 1);
  localparam logic [9:0] FRAME_VLINE = 10'(FRAME_LINE);
  localparam logic [3:0] BLANK       = 4'hF;

  state_t      state;
  logic [15:0] shadow;
  logic [7:0]  frame_cnt;
  logic        load_ready;
  logic        frame_pulse;
  logic        load_fire;
  logic [3:0]  slot;
  logic [3:0]  digit_next;

  function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) r[i*4 +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Returns {carry_out, sum}; carry_out is set only when 9999 rolls to 0000.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return {carry, r};
  endfunction

  assign frame_pulse       = (i_vpos == FRAME_VLINE) && (i_hpos == 10'd0);
  assign load_fire         = load.i_load_valid && load_ready;
  assign load.o_load_ready = load_ready;

  // Priority: clear, then pending-load apply, then load acceptance / counting.
  // NOTE: every register here is updated with <= so all branches read the pre-edge state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      o_value    <= 16'h0000;
      shadow     <= 16'h0000;
      frame_cnt  <= 8'd0;
      o_wrap     <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      o_wrap <= 1'b0;
      if (i_clear) begin
        o_value    <= 16'h0000;
        frame_cnt  <= 8'd0;
        state      <= i_run ? RUN : IDLE;
        load_ready <= 1'b1;
      end else if (state == LOAD_WAIT) begin
        // Acceptance always moved us here on an earlier edge, so this pulse is strictly later.
        if (frame_pulse) begin
          o_value    <= shadow;
          frame_cnt  <= 8'd0;
          state      <= i_run ? RUN : IDLE;
          load_ready <= 1'b1;
        end
      end else begin
        if (load_fire) begin
          shadow     <= clamp_bcd(load.i_load_value);
          state      <= LOAD_WAIT;
          load_ready <= 1'b0;
        end else begin
          state <= i_run ? RUN : IDLE;
        end
        if (state == RUN && frame_pulse) begin
          if (frame_cnt == TICK_LAST) begin
            frame_cnt         <= 8'd0;
            {o_wrap, o_value} <= bcd_inc(o_value);
          end else begin
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
      end
    end
  end

  assign slot = i_hpos[7:4];

  // NOTE: digit_next gets a default before the case so no latch is inferred.
  always_comb begin
    digit_next = BLANK;
    case (slot)
      4'd0:    digit_next = o_value[15:12];
      4'd1:    digit_next = o_value[11:8];
      4'd2:    digit_next = o_value[7:4];
      4'd3:    digit_next = o_value[3:0];
      default: digit_next = BLANK;
    endcase
`ifdef DIGIT_SEQ_LEADING_BLANK_EN
    if ((slot == 4'd0) && (o_value[15:12] == 4'd0)) digit_next = BLANK;
    if ((slot == 4'd1) && (o_value[15:8]  == 8'd0)) digit_next = BLANK;
    if ((slot == 4'd2) && (o_value[15:4]  == 12'd0)) digit_next = BLANK;
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_digit <= BLANK;
    end else begin
      o_digit <= digit_next;
    end
  end

endmodule

// File: tb/tb_digit_sequencer.sv
// Directed bench for digit_sequencer: dut_a ticks every 2 frames, dut_b every frame.
// Expected values are hand-computed constants; inputs change 1 time unit after each rising edge.
module tb_digit_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic        run_a;
  logic        run_b;
  logic        clear;
  logic [3:0]  digit_a, digit_b;
  logic [15:0] value_a, value_b;
  logic        wrap_a, wrap_b;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [3:0] exp_digit [16];

  digit_sequencer_if load_a ();
  digit_sequencer_if load_b ();

  digit_sequencer #(.FRAMES_PER_TICK(2), .FRAME_LINE(480)) dut_a (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_hpos  (hpos),
    .i_vpos  (vpos),
    .i_run   (run_a),
    .i_clear (clear),
    .load    (load_a),
    .o_digit (digit_a),
    .o_value (value_a),
    .o_wrap  (wrap_a)
  );

  digit_sequencer #(.FRAMES_PER_TICK(1), .FRAME_LINE(480)) dut_b (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_hpos  (hpos),
    .i_vpos  (vpos),
    .i_run   (run_b),
    .i_clear (clear),
    .load    (load_b),
    .o_digit (digit_b),
    .o_value (value_b),
    .o_wrap  (wrap_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    hpos = 10'd0;
    vpos = 10'd480;
    tick();
    hpos = 10'd800;
    vpos = 10'd0;
  endtask

  initial begin
    rst   = 1'b1;
    hpos  = 10'd800;
    vpos  = 10'd0;
    run_a = 1'b0;
    run_b = 1'b0;
    clear = 1'b0;
    load_a.i_load_valid = 1'b0;
    load_a.i_load_value = 16'h0000;
    load_b.i_load_valid = 1'b0;
    load_b.i_load_value = 16'h0000;

    for (int s = 0; s < 16; s++) exp_digit[s] = 4'hF;
`ifdef DIGIT_SEQ_LEADING_BLANK_EN
    exp_digit[0] = 4'hF;
`else
    exp_digit[0] = 4'h0;
`endif
    exp_digit[1] = 4'h5;
    exp_digit[2] = 4'h0;
    exp_digit[3] = 4'h7;

    // Reset state
    tick();
    tick();
    check("rst_value",  value_a, 16'h0000);
    check("rst_ready",  16'(load_a.o_load_ready), 16'h0001);
    check("rst_digit",  16'(digit_a), 16'h000F);
    check("rst_wrap",   16'(wrap_a), 16'h0000);
    check("rst_value_b", value_b, 16'h0000);
    rst = 1'b0;
    tick();

    // Two frames per tick: 6 pulses -> 0003
    run_a = 1'b1;
    tick();
    tick();
    frame();
    check("fpt2_pulse1", value_a, 16'h0000);
    frame();
    check("fpt2_pulse2", value_a, 16'h0001);
    frame();
    frame();
    frame();
    frame();
    check("fpt2_pulse6", value_a, 16'h0003);

    // Counting suspended in IDLE
    run_a = 1'b0;
    tick();
    tick();
    frame();
    frame();
    check("idle_hold", value_a, 16'h0003);

    // Load 12A4 accepted in a frame-pulse cycle; applies only at the next pulse
    load_a.i_load_valid = 1'b1;
    load_a.i_load_value = 16'h12A4;
    hpos = 10'd0;
    vpos = 10'd480;
    tick();
    load_a.i_load_valid = 1'b0;
    hpos = 10'd800;
    vpos = 10'd0;
    check("load_ready_low", 16'(load_a.o_load_ready), 16'h0000);
    check("load_not_same_pulse", value_a, 16'h0003);
    tick();
    tick();
    tick();
    check("load_ready_still_low", 16'(load_a.o_load_ready), 16'h0000);
    check("load_value_held", value_a, 16'h0003);
    frame();
    check("load_apply_clamped", value_a, 16'h1294);
    check("load_ready_back", 16'(load_a.o_load_ready), 16'h0001);

    // Digit mux sweep with value 0507
    load_a.i_load_valid = 1'b1;
    load_a.i_load_value = 16'h0507;
    tick();
    load_a.i_load_valid = 1'b0;
    frame();
    check("load_0507", value_a, 16'h0507);
    for (int h = 0; h < 256; h++) begin
      hpos = 10'(h);
      tick();
      check($sformatf("digit_h%0d", h), 16'(digit_a), 16'(exp_digit[h / 16]));
    end
    hpos = 10'h310;
    #1;
    check("digit_latency", 16'(digit_a), 16'h000F);
    tick();
    check("digit_hpos_hi_ignored", 16'(digit_a), 16'h0005);
    hpos = 10'd800;

    // Clear together with a load request: load discarded
    load_a.i_load_valid = 1'b1;
    load_a.i_load_value = 16'h0042;
    tick();
    load_a.i_load_valid = 1'b0;
    frame();
    check("load_0042", value_a, 16'h0042);
    clear = 1'b1;
    load_a.i_load_valid = 1'b1;
    load_a.i_load_value = 16'h1111;
    tick();
    clear = 1'b0;
    load_a.i_load_valid = 1'b0;
    check("clear_value", value_a, 16'h0000);
    check("clear_ready", 16'(load_a.o_load_ready), 16'h0001);
    frame();
    check("clear_load_discarded", value_a, 16'h0000);

    // Clear beats a pending-load apply on the same pulse
    load_a.i_load_valid = 1'b1;
    load_a.i_load_value = 16'h0042;
    tick();
    load_a.i_load_valid = 1'b0;
    check("pend_ready_low", 16'(load_a.o_load_ready), 16'h0000);
    clear = 1'b1;
    hpos  = 10'd0;
    vpos  = 10'd480;
    tick();
    clear = 1'b0;
    hpos  = 10'd800;
    vpos  = 10'd0;
    check("clear_over_apply", value_a, 16'h0000);
    check("clear_over_apply_ready", 16'(load_a.o_load_ready), 16'h0001);
    frame();
    check("clear_pending_dropped", value_a, 16'h0000);

    // One frame per tick: load 9998, wrap through 0000
    run_b = 1'b1;
    tick();
    tick();
    load_b.i_load_valid = 1'b1;
    load_b.i_load_value = 16'h9998;
    tick();
    load_b.i_load_valid = 1'b0;
    check("b_ready_low", 16'(load_b.o_load_ready), 16'h0000);
    check("b_value_pre", value_b, 16'h0000);
    frame();
    check("b_apply_9998", value_b, 16'h9998);
    check("b_wrap_0", 16'(wrap_b), 16'h0000);
    frame();
    check("b_inc_9999", value_b, 16'h9999);
    check("b_wrap_1", 16'(wrap_b), 16'h0000);
    frame();
    check("b_wrap_0000", value_b, 16'h0000);
    check("b_wrap_pulse", 16'(wrap_b), 16'h0001);
    tick();
    check("b_wrap_cleared", 16'(wrap_b), 16'h0000);

    // Reset in LOAD_WAIT discards the pending load
    run_b = 1'b0;
    tick();
    load_b.i_load_valid = 1'b1;
    load_b.i_load_value = 16'h5555;
    tick();
    load_b.i_load_valid = 1'b0;
    check("b_pend_ready_low", 16'(load_b.o_load_ready), 16'h0000);
    rst = 1'b1;
    #1;
    check("rst_async_ready", 16'(load_b.o_load_ready), 16'h0001);
    tick();
    rst = 1'b0;
    tick();
    check("rst_mid_load_value", value_b, 16'h0000);
    check("rst_mid_load_ready", 16'(load_b.o_load_ready), 16'h0001);
    frame();
    check("rst_no_stale_apply", value_b, 16'h0000);
    check("rst_no_stale_ready", 16'(load_b.o_load_ready), 16'h0001);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
